// File: rtl/secded_pkg.sv
// Shared types and elaboration-time helpers for the Hamming SECDED decoder.
// Codeword layout: cw[0]=overall parity, cw[2**k]=check bits, data ascending in the rest.
package secded_pkg;

    localparam int MAX_NW = 64;

    typedef enum logic [1:0] {
        ST_OK  = 2'd0,
        ST_SEC = 2'd1,
        ST_PAR = 2'd2,
        ST_DED = 2'd3
    } status_e;

    // Smallest number of Hamming check bits covering DW data bits plus the check bits themselves.
    function automatic int calc_pw(input int dw);
        int p;
        p = 1;
        while ((1 << p) < dw + p + 1) begin
            p++;
        end
        return p;
    endfunction

    function automatic logic is_pow2(input int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // 1-based index of the data bit sitting at codeword position pos.
    function automatic int data_ordinal(input int pos);
        int n;
        n = 0;
        for (int i = 1; i < MAX_NW; i++) begin
            if (i <= pos && !is_pow2(i)) begin
                n++;
            end
        end
        return n;
    endfunction

    // Positions beyond the real codeword are zero, so the unused upper data bits come out zero too.
    function automatic logic [MAX_NW-1:0] extract_data(input logic [MAX_NW-1:0] cw);
        logic [MAX_NW-1:0] d;
        int                k;
        d = '0;
        k = 0;
        for (int i = 1; i < MAX_NW; i++) begin
            if (!is_pow2(i)) begin
                d[k] = cw[i];
                k++;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/secded_syndrome.sv
// Combinational syndrome (XOR of set-bit positions) and overall parity of one codeword.
module secded_syndrome
    import secded_pkg::*;
#(
    parameter  int DW = 11,
    localparam int PW = calc_pw(DW),
    localparam int NW = DW + PW + 1
) (
    input  logic [NW-1:0] cw_i,
    output logic [PW-1:0] syn_o,
    output logic          ov_o
);

    always_comb begin
        syn_o = '0;
        for (int i = 1; i < NW; i++) begin
            if (cw_i[i]) begin
                syn_o = syn_o ^ PW'(i);
            end
        end
    end

    assign ov_o = ^cw_i;

endmodule

// File: rtl/secded_dec_pipe.sv
// Pipelined SECDED decoder with saturating error counters: 2-cycle latency, 1 word/cycle.
// Backpressure: out_ready low holds stage 2, which then holds stage 1 and drops in_ready.
module secded_dec_pipe
    import secded_pkg::*;
#(
    parameter  int DW = 11,
    parameter  int CW = 8,
    localparam int PW = calc_pw(DW),
    localparam int NW = DW + PW + 1,
    localparam int EW = $clog2(DW + 1)
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [NW-1:0] in_cw,
    input  logic          corr_en,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    out_status,
    output logic [EW-1:0] out_errpos,
    input  logic          cnt_clr,
    output logic [CW-1:0] cnt_single,
    output logic [CW-1:0] cnt_double
);

    logic          s1_adv;
    logic          accept;
    logic          deliver;

    logic [PW-1:0] s1_syn_d;
    logic          s1_ov_d;

    logic          s1_v_q;
    logic [PW-1:0] s1_syn_q;
    logic          s1_ov_q;
    logic [NW-1:0] s1_cw_q;
    logic          s1_corr_q;

    logic [DW-1:0] s2_data_d;
    status_e       s2_status_d;
    logic [EW-1:0] s2_errpos_d;
    logic [NW-1:0] cw_fix;
    int            syn_pos;

    logic          s2_v_q;
    logic [DW-1:0] s2_data_q;
    status_e       s2_status_q;
    logic [EW-1:0] s2_errpos_q;

    logic [CW-1:0] cnt_single_d;
    logic [CW-1:0] cnt_single_q;
    logic [CW-1:0] cnt_double_d;
    logic [CW-1:0] cnt_double_q;

    assign s1_adv   = !s2_v_q || out_ready;
    assign in_ready = !s1_v_q || s1_adv;
    assign accept   = in_valid && in_ready;
    assign deliver  = s2_v_q && out_ready;

    secded_syndrome #(.DW(DW)) u_syndrome (
        .cw_i  (in_cw),
        .syn_o (s1_syn_d),
        .ov_o  (s1_ov_d)
    );

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            s1_v_q    <= 1'b0;
            s1_syn_q  <= '0;
            s1_ov_q   <= 1'b0;
            s1_cw_q   <= '0;
            s1_corr_q <= 1'b0;
        end else if (in_ready) begin
            s1_v_q <= in_valid;
            if (accept) begin
                s1_syn_q  <= s1_syn_d;
                s1_ov_q   <= s1_ov_d;
                s1_cw_q   <= in_cw;
                s1_corr_q <= corr_en;
            end
        end
    end

    assign syn_pos = int'(s1_syn_q);

    // Check-bit hits are reported as PAR; only syndromes landing on a data position can be corrected.
    always_comb begin
        s2_status_d = ST_OK;
        s2_errpos_d = '0;
        cw_fix      = s1_cw_q;
        if (s1_syn_q == '0) begin
            s2_status_d = s1_ov_q ? ST_PAR : ST_OK;
        end else if (!s1_ov_q) begin
            s2_status_d = ST_DED;
        end else if (syn_pos >= NW) begin
            s2_status_d = ST_DED;
        end else if (is_pow2(syn_pos)) begin
            s2_status_d = ST_PAR;
        end else begin
            s2_status_d = ST_SEC;
            s2_errpos_d = EW'(data_ordinal(syn_pos));
            if (s1_corr_q) begin
                cw_fix = s1_cw_q ^ (NW'(1) << s1_syn_q);
            end
        end
        s2_data_d = DW'(extract_data(MAX_NW'(cw_fix)));
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            s2_v_q      <= 1'b0;
            s2_data_q   <= '0;
            s2_status_q <= ST_OK;
            s2_errpos_q <= '0;
        end else if (s1_adv) begin
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                s2_data_q   <= s2_data_d;
                s2_status_q <= s2_status_d;
                s2_errpos_q <= s2_errpos_d;
            end
        end
    end

    always_comb begin
        cnt_single_d = cnt_single_q;
        cnt_double_d = cnt_double_q;
        if (cnt_clr) begin
            cnt_single_d = '0;
            cnt_double_d = '0;
        end else if (deliver) begin
            if ((s2_status_q == ST_SEC || s2_status_q == ST_PAR) && cnt_single_q != '1) begin
                cnt_single_d = cnt_single_q + CW'(1);
            end
            if (s2_status_q == ST_DED && cnt_double_q != '1) begin
                cnt_double_d = cnt_double_q + CW'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            cnt_single_q <= '0;
            cnt_double_q <= '0;
        end else begin
            cnt_single_q <= cnt_single_d;
            cnt_double_q <= cnt_double_d;
        end
    end

    assign out_valid  = s2_v_q;
    assign out_data   = s2_data_q;
    assign out_status = s2_status_q;
    assign out_errpos = s2_errpos_q;
    assign cnt_single = cnt_single_q;
    assign cnt_double = cnt_double_q;

endmodule

// File: tb/tb_secded_dec_pipe.sv
// Directed bench for secded_dec_pipe at DW=11; a second instance with CW=2 covers counter saturation.
module tb_secded_dec_pipe;

    logic        Clk;
    logic        Reset_n;
    logic        in_valid;
    logic [15:0] in_cw;
    logic        corr_en;
    logic        out_ready;
    logic        cnt_clr;

    logic        in_ready;
    logic        out_valid;
    logic [10:0] out_data;
    logic [1:0]  out_status;
    logic [3:0]  out_errpos;
    logic [7:0]  cnt_single;
    logic [7:0]  cnt_double;

    logic        in_ready2;
    logic        out_valid2;
    logic [10:0] out_data2;
    logic [1:0]  out_status2;
    logic [3:0]  out_errpos2;
    logic [1:0]  cnt_single2;
    logic [1:0]  cnt_double2;

    int checks   = 0;
    int failures = 0;

    secded_dec_pipe #(.DW(11), .CW(8)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_cw      (in_cw),
        .corr_en    (corr_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_status (out_status),
        .out_errpos (out_errpos),
        .cnt_clr    (cnt_clr),
        .cnt_single (cnt_single),
        .cnt_double (cnt_double)
    );

    secded_dec_pipe #(.DW(11), .CW(2)) dut2 (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready2),
        .in_cw      (in_cw),
        .corr_en    (corr_en),
        .out_valid  (out_valid2),
        .out_ready  (out_ready),
        .out_data   (out_data2),
        .out_status (out_status2),
        .out_errpos (out_errpos2),
        .cnt_clr    (cnt_clr),
        .cnt_single (cnt_single2),
        .cnt_double (cnt_double2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    // Offers one word, waits (bounded) for acceptance and then for its result to reach the output.
    task automatic drive_one(input logic [15:0] cw, input logic ce);
        int n;
        in_cw    = cw;
        corr_en  = ce;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            cyc();
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL drive_accept in_ready=%b required=1", in_ready);
        end
        cyc();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            cyc();
            n++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL drive_result out_valid=%b required=1", out_valid);
        end
    endtask

    task automatic test_reset();
        Reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_cw     = 16'h0000;
        corr_en   = 1'b1;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        cyc();
        cyc();
        Reset_n = 1'b1;
        checks++;
        if ({out_valid, out_data, out_status, out_errpos} !== {1'b0, 11'h000, 2'd0, 4'd0}) begin
            failures++;
            $display("FAIL reset_outputs got=%b_%h_%0d_%0d required=0_000_0_0",
                     out_valid, out_data, out_status, out_errpos);
        end
        checks++;
        if ({cnt_single, cnt_double} !== 16'h0000) begin
            failures++;
            $display("FAIL reset_counters got=%0d/%0d required=0/0", cnt_single, cnt_double);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b required=1", in_ready);
        end
    endtask

    task automatic test_sec_latency();
        in_cw    = 16'h0008;
        corr_en  = 1'b1;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL sec_early_valid got=%b required=0", out_valid);
        end
        cyc();
        checks++;
        if ({out_valid, out_data, out_status, out_errpos} !== {1'b1, 11'h000, 2'd1, 4'd1}) begin
            failures++;
            $display("FAIL sec_result got=%b_%h_%0d_%0d required=1_000_1_1",
                     out_valid, out_data, out_status, out_errpos);
        end
        checks++;
        if (cnt_single !== 8'd0) begin
            failures++;
            $display("FAIL sec_cnt_before_deliver got=%0d required=0", cnt_single);
        end
        cyc();
        checks++;
        if ({out_valid, cnt_single} !== {1'b0, 8'd1}) begin
            failures++;
            $display("FAIL sec_cnt_after got=%b_%0d required=0_1", out_valid, cnt_single);
        end
    endtask

    task automatic test_classes();
        drive_one(16'h000F, 1'b1);
        checks++;
        if ({out_data, out_status, out_errpos} !== {11'h001, 2'd0, 4'd0}) begin
            failures++;
            $display("FAIL ok_word got=%h_%0d_%0d required=001_0_0", out_data, out_status, out_errpos);
        end
        cyc();
        drive_one(16'h0028, 1'b1);
        checks++;
        if ({out_data, out_status, out_errpos} !== {11'h003, 2'd3, 4'd0}) begin
            failures++;
            $display("FAIL ded_word got=%h_%0d_%0d required=003_3_0", out_data, out_status, out_errpos);
        end
        cyc();
        checks++;
        if (cnt_double !== 8'd1) begin
            failures++;
            $display("FAIL ded_count got=%0d required=1", cnt_double);
        end
        drive_one(16'h0001, 1'b1);
        checks++;
        if ({out_data, out_status, out_errpos} !== {11'h000, 2'd2, 4'd0}) begin
            failures++;
            $display("FAIL par_p0 got=%h_%0d_%0d required=000_2_0", out_data, out_status, out_errpos);
        end
        cyc();
        drive_one(16'h0100, 1'b1);
        checks++;
        if ({out_data, out_status, out_errpos} !== {11'h000, 2'd2, 4'd0}) begin
            failures++;
            $display("FAIL par_check8 got=%h_%0d_%0d required=000_2_0", out_data, out_status, out_errpos);
        end
        cyc();
        checks++;
        if ({cnt_single, cnt_double} !== {8'd3, 8'd1}) begin
            failures++;
            $display("FAIL class_counts got=%0d/%0d required=3/1", cnt_single, cnt_double);
        end
    endtask

    task automatic test_corr_en();
        drive_one(16'h8000, 1'b0);
        checks++;
        if ({out_data, out_status, out_errpos} !== {11'h400, 2'd1, 4'd11}) begin
            failures++;
            $display("FAIL detect_only got=%h_%0d_%0d required=400_1_11", out_data, out_status, out_errpos);
        end
        cyc();
        drive_one(16'h8000, 1'b1);
        checks++;
        if ({out_data, out_status, out_errpos} !== {11'h000, 2'd1, 4'd11}) begin
            failures++;
            $display("FAIL correct_top got=%h_%0d_%0d required=000_1_11", out_data, out_status, out_errpos);
        end
        cyc();
        checks++;
        if (cnt_single !== 8'd5) begin
            failures++;
            $display("FAIL corr_count got=%0d required=5", cnt_single);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        corr_en   = 1'b1;
        in_valid  = 1'b1;
        in_cw     = 16'h000F;
        cyc();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second_ready got=%b required=1", in_ready);
        end
        in_cw = 16'h0008;
        cyc();
        in_cw = 16'h0033;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL b2b_stall_ready cycle=%0d got=%b required=0", i, in_ready);
            end
            checks++;
            if ({out_valid, out_data, out_status} !== {1'b1, 11'h001, 2'd0}) begin
                failures++;
                $display("FAIL b2b_hold cycle=%0d got=%b_%h_%0d required=1_001_0",
                         i, out_valid, out_data, out_status);
            end
            cyc();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_release_ready got=%b required=1", in_ready);
        end
        cyc();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_data, out_status, out_errpos} !== {1'b1, 11'h000, 2'd1, 4'd1}) begin
            failures++;
            $display("FAIL b2b_word2 got=%b_%h_%0d_%0d required=1_000_1_1",
                     out_valid, out_data, out_status, out_errpos);
        end
        cyc();
        checks++;
        if ({out_valid, out_data, out_status, out_errpos} !== {1'b1, 11'h002, 2'd0, 4'd0}) begin
            failures++;
            $display("FAIL b2b_word3 got=%b_%h_%0d_%0d required=1_002_0_0",
                     out_valid, out_data, out_status, out_errpos);
        end
        cyc();
        checks++;
        if ({out_valid, cnt_single} !== {1'b0, 8'd6}) begin
            failures++;
            $display("FAIL b2b_drain got=%b_%0d required=0_6", out_valid, cnt_single);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp2;
        cnt_clr = 1'b1;
        cyc();
        cnt_clr = 1'b0;
        checks++;
        if ({cnt_single2, cnt_single, cnt_double} !== {2'd0, 8'd0, 8'd0}) begin
            failures++;
            $display("FAIL sat_clear got=%0d/%0d/%0d required=0/0/0", cnt_single2, cnt_single, cnt_double);
        end
        for (int n = 1; n <= 6; n++) begin
            drive_one(16'h0008, 1'b1);
            cyc();
            exp2 = (n < 3) ? 2'(n) : 2'd3;
            checks++;
            if (cnt_single2 !== exp2) begin
                failures++;
                $display("FAIL sat_count word=%0d got=%0d required=%0d", n, cnt_single2, exp2);
            end
        end
        checks++;
        if (cnt_single !== 8'd6) begin
            failures++;
            $display("FAIL sat_wide_count got=%0d required=6", cnt_single);
        end
        drive_one(16'h0008, 1'b1);
        cnt_clr = 1'b1;
        cyc();
        cnt_clr = 1'b0;
        checks++;
        if ({cnt_single2, cnt_single} !== {2'd0, 8'd0}) begin
            failures++;
            $display("FAIL clr_wins got=%0d/%0d required=0/0", cnt_single2, cnt_single);
        end
    endtask

    task automatic test_reset_midstream();
        drive_one(16'h0028, 1'b1);
        cyc();
        checks++;
        if (cnt_double !== 8'd1) begin
            failures++;
            $display("FAIL mid_pre_count got=%0d required=1", cnt_double);
        end
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_cw     = 16'h0008;
        cyc();
        in_cw = 16'h000F;
        cyc();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL mid_in_flight got=%b required=1", out_valid);
        end
        Reset_n = 1'b0;
        cyc();
        Reset_n = 1'b1;
        checks++;
        if ({out_valid, cnt_single, cnt_double, in_ready} !== {1'b0, 8'd0, 8'd0, 1'b1}) begin
            failures++;
            $display("FAIL mid_reset got=%b_%0d_%0d_%b required=0_0_0_1",
                     out_valid, cnt_single, cnt_double, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL mid_stale cycle=%0d got=%b required=0", i, out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sec_latency();
        test_classes();
        test_corr_en();
        test_back_to_back();
        test_saturation();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
